ram_checksum: RTL and testbench

- Parametrised single-port RAM with a built-in checksum engine.
- Generalises the 16x8 scratch RAM:
  - width and depth are parameters;
  - reads are registered;
  - an FSM sweeps a programmable address window and produces a two's-complement checksum byte/word.
- Sits between the data loader and the checksum verifier; the verifier consumes `cs_sum`.

---
 rtl/ram_checksum.sv | 69 ++++++
 tb/tb_ram_checksum.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ram_checksum.sv
// ram_checksum: single-port RAM with registered reads and a windowed two's-complement checksum sweep.
module ram_checksum #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeE,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              cs_start,
  input  logic [ADDR_W-1:0] cs_base,
  input  logic [ADDR_W:0]   cs_len,
  output logic              cs_busy,
  output logic              cs_done,
  output logic [DATA_W-1:0] cs_sum
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, sum_q, acc_q, acc_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q, len_d;
  assign acc_d   = acc_q + mem_q[ptr_q];
  assign len_d   = cs_len > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : cs_len;
  assign dout    = dout_q;
  assign cs_sum  = sum_q;
  assign cs_busy = state_q != IDLE;
  assign cs_done = state_q == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q <= IDLE;
      dout_q  <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (writeE) mem_q[adr] <= din;
          dout_q <= writeE ? din : mem_q[adr];
          if (cs_start) begin
            acc_q   <= '0;
            ptr_q   <= cs_base;
            cnt_q   <= len_d;
            state_q <= cs_len == '0 ? DONE : SCAN;
            if (cs_len == '0) sum_q <= '0;
          end
        end
        SCAN: begin
          acc_q <= acc_d;
          ptr_q <= ptr_q + ADDR_W'(1);
          cnt_q <= cnt_q - (ADDR_W+1)'(1);
          // last word: publish the negated running sum so sum + cs_sum wraps to zero
          if (cnt_q == (ADDR_W+1)'(1)) begin
            state_q <= DONE;
            sum_q   <= -acc_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_checksum.sv
// tb_ram_checksum: directed vector table plus checksum sweep sequences for ram_checksum.
module tb_ram_checksum;
  logic       clk = 0, reset = 1, writeE = 0, cs_start = 0;
  logic [3:0] adr = 0, cs_base = 0;
  logic [7:0] din = 0;
  logic [4:0] cs_len = 0;
  logic [7:0] dout, cs_sum;
  logic       cs_busy, cs_done;
  int checks = 0, fails = 0;

  ram_checksum dut (
    .clk(clk), .reset(reset), .writeE(writeE), .adr(adr), .din(din), .dout(dout),
    .cs_start(cs_start), .cs_base(cs_base), .cs_len(cs_len),
    .cs_busy(cs_busy), .cs_done(cs_done), .cs_sum(cs_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input string name);
    writeE = 0;
    adr    = a;
    @(negedge clk);
    check(name, dout, exp);
  endtask

  task automatic sweep(input logic [3:0] base, input logic [4:0] len, input logic [7:0] exp_sum,
                       input bit perturb, input bit rst_mid, input string tag);
    int done_at = 0, busy_n = 0, dones = 0;
    int eff = len == 0 ? 0 : (len > 16 ? 16 : int'(len));
    int exp_done = rst_mid ? 0 : eff + 1;
    int exp_busy = rst_mid ? 3 : eff + 1;
    writeE = 0;
    adr    = 2;
    @(negedge clk);
    cs_start = 1;
    cs_base  = base;
    cs_len   = len;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (cs_busy) busy_n++;
      if (cs_done) begin
        dones++;
        if (done_at == 0) begin
          done_at = c;
          check({tag, " sum at done"}, cs_sum, exp_sum);
          check({tag, " dout held"}, dout, 8'h7F);
        end
      end
      if (c == 1) begin
        cs_start = 0;
        cs_base  = 4'd9;
        cs_len   = 5'd7;
      end
      if (perturb && c == 2) begin
        cs_start = 1;
        writeE   = 1;
        adr      = 0;
        din      = 8'hFF;
      end
      if (perturb && c == 3) begin
        cs_start = 0;
        writeE   = 0;
        adr      = 2;
      end
      if (rst_mid && c == 3) begin
        #2 reset = 1;
        #1;
        check({tag, " busy in reset"}, cs_busy, 0);
        check({tag, " sum in reset"}, cs_sum, 0);
        #1 reset = 0;
      end
    end
    check({tag, " done cycle"}, done_at, exp_done);
    check({tag, " done count"}, dones, rst_mid ? 0 : 1);
    check({tag, " busy cycles"}, busy_n, exp_busy);
    check({tag, " sum held"}, cs_sum, exp_sum);
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{1'b1, 4'd0,  8'h80, 8'h80};
    vt[1]  = '{1'b1, 4'd1,  8'h01, 8'h01};
    vt[2]  = '{1'b1, 4'd2,  8'h7F, 8'h7F};
    vt[3]  = '{1'b1, 4'd3,  8'h10, 8'h10};
    vt[4]  = '{1'b1, 4'd14, 8'h03, 8'h03};
    vt[5]  = '{1'b1, 4'd15, 8'h05, 8'h05};
    vt[6]  = '{1'b0, 4'd1,  8'h00, 8'h01};
    vt[7]  = '{1'b0, 4'd0,  8'h00, 8'h80};
    vt[8]  = '{1'b1, 4'd5,  8'hAA, 8'hAA};
    vt[9]  = '{1'b0, 4'd5,  8'h00, 8'hAA};
    vt[10] = '{1'b0, 4'd14, 8'h00, 8'h03};
    vt[11] = '{1'b0, 4'd2,  8'h00, 8'h7F};

    repeat (2) @(negedge clk);
    reset = 0;
    check("reset dout", dout, 0);
    check("reset busy", cs_busy, 0);
    check("reset done", cs_done, 0);
    check("reset sum", cs_sum, 0);

    writeE = 1; adr = 7; din = 8'h55;
    @(negedge clk);
    writeE = 0;
    check("pre-reset write", dout, 8'h55);
    @(posedge clk);
    #3 reset = 1;
    #1;
    check("async reset dout", dout, 0);
    check("async reset sum", cs_sum, 0);
    check("async reset busy", cs_busy, 0);
    @(negedge clk);
    reset = 0;
    for (int a = 0; a < 16; a++) read_chk(4'(a), 8'h00, "cleared word");

    for (int i = 0; i < 12; i++) begin
      writeE = vt[i].we;
      adr    = vt[i].a;
      din    = vt[i].d;
      @(negedge clk);
      check($sformatf("vec %0d dout", i), dout, vt[i].exp);
    end
    writeE = 0;

    sweep(4'd0,  5'd4,  8'hF0, 0, 0, "base0 len4");
    sweep(4'd14, 5'd4,  8'h77, 0, 0, "wrap len4");
    sweep(4'd0,  5'd0,  8'h00, 0, 0, "len0");
    sweep(4'd0,  5'd4,  8'hF0, 1, 0, "busy block");
    read_chk(4'd0, 8'h80, "mem0 after blocked write");
    sweep(4'd0,  5'd16, 8'h3E, 0, 0, "full depth");
    sweep(4'd3,  5'd20, 8'h3E, 0, 0, "len clamp");
    sweep(4'd0,  5'd16, 8'h00, 0, 1, "reset mid");
    read_chk(4'd0, 8'h00, "mem0 after mid reset");
    read_chk(4'd2, 8'h00, "mem2 after mid reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
